// File: rtl/sym_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : sym_frame_packer
// Description : Packs a serial stream of 2-bit symbols into 8-symbol frames.
//               An accumulator collects symbols, and the closed frame then
//               moves into an output hold register. That register stays
//               stable until the consumer handshakes it. A flush closes a
//               partial frame, and its empty slots are padded with PAD_SYM.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_frame_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [1:0] in_data_i,
    input  logic       flush_i,
    output logic [1:0] data0_o,
    output logic [1:0] data1_o,
    output logic [1:0] data2_o,
    output logic [1:0] data3_o,
    output logic [1:0] data4_o,
    output logic [1:0] data5_o,
    output logic [1:0] data6_o,
    output logic [1:0] data7_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [3:0] out_cnt_o,
    output logic [7:0] frame_cnt_o
);

    localparam logic [1:0]  PAD_SYM   = 2'b00;
    localparam logic [15:0] ACC_CLEAR = {8{PAD_SYM}};
    localparam logic [3:0]  FRAME_LEN = 4'd8;

    // Accumulator state
    logic [15:0] acc_q, acc_d;
    logic [3:0]  fill_q, fill_d;
    logic        acc_full_q, acc_full_d;

    // Output hold register
    logic [15:0] hold_q;
    logic [3:0]  out_cnt_q;
    logic        out_valid_q;
    logic [7:0]  frame_cnt_q;

    logic        hold_free;
    logic        xfer;
    logic        accept;
    logic        handshake;
    logic [15:0] base_acc;
    logic [3:0]  base_fill;
    logic        base_full;

    assign hold_free  = !out_valid_q || out_ready_i;
    assign xfer       = acc_full_q && hold_free;
    // in_ready is combinational from out_ready, so a stalled packer resumes
    // in the same cycle that the consumer frees the hold register.
    assign in_ready_o = !rst && (!acc_full_q || hold_free);
    assign accept     = in_valid_i && in_ready_o;
    assign handshake  = out_valid_q && out_ready_i;

    // Next accumulator state. A transfer first clears the accumulator, so a
    // symbol accepted in the same cycle lands in slot 0 of the new frame.
    always_comb begin
        base_acc   = xfer ? ACC_CLEAR : acc_q;
        base_fill  = xfer ? 4'd0 : fill_q;
        base_full  = acc_full_q && !xfer;
        acc_d      = base_acc;
        fill_d     = base_fill;
        acc_full_d = base_full;
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                if (base_fill == 4'(i)) begin
                    acc_d[2*i +: 2] = in_data_i;
                end
            end
            fill_d = base_fill + 4'd1;
        end
        // Close on the eighth symbol, or on a flush when the frame is non-empty
        // (this includes the symbol accepted in the same cycle).
        if (!base_full && ((accept && fill_d == FRAME_LEN) ||
                           (flush_i && fill_d != 4'd0))) begin
            acc_full_d = 1'b1;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= ACC_CLEAR;
            fill_q     <= 4'd0;
            acc_full_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            acc_full_q <= acc_full_d;
        end
    end

    // Hold register: load on transfer, and drop valid on a handshake without a refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= 16'd0;
            out_cnt_q   <= 4'd0;
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            hold_q      <= acc_q;
            out_cnt_q   <= fill_q;
            out_valid_q <= 1'b1;
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completed-handshake counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 8'd0;
        end else if (handshake) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign data0_o     = hold_q[1:0];
    assign data1_o     = hold_q[3:2];
    assign data2_o     = hold_q[5:4];
    assign data3_o     = hold_q[7:6];
    assign data4_o     = hold_q[9:8];
    assign data5_o     = hold_q[11:10];
    assign data6_o     = hold_q[13:12];
    assign data7_o     = hold_q[15:14];
    assign out_valid_o = out_valid_q;
    assign out_cnt_o   = out_cnt_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire
